rot_arbiter: RTL and testbench
==============================

# rot_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit rotate-right shifter. It accepts rotate jobs (data plus amount) from requester A or B over valid/ready handshakes. It grants one job per cycle into the shared rotator and registers the result in a single-entry output stage, tagged with the source. It sits between the two client blocks and the shared rotate datapath.

## Interface
- `WIDTH`, default 4: data width; must be a power of two ≥ 2.
- `AMT_W`, default 2: rotate-amount width, equal to log2(`WIDTH`).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high, clears all state.
- `a_valid`  input  1  requester A has a job.
- `a_ready`  output  1  A's job is accepted this cycle.
- `a_data`  input  WIDTH  A operand.
- `a_amt`  input  AMT_W  A rotate-right amount.
- `b_valid`, `b_ready`, `b_data`, `b_amt`: same as the A ports, for requester B.
- `out_valid`  output  1  result held in the output register.
- `out_ready`  input  1  consumer takes the result.
- `out_data`  output  WIDTH  rotated result.
- `out_src`  output  1  source of the result: 0 = A, 1 = B.
- `cnt_a`, `cnt_b`  output  8  completion counters; present only with `ROT_ARB_STATS_EN`.

## Operation
- Rotate right: `out_data[i] = data[(i+amt) mod WIDTH]`; amt = 0 passes data unchanged; the wrap-around is modulo `WIDTH`.
- The output slot is free when `!out_valid || out_ready`.
- Grant is combinational and applies only when the slot is free:
  - Only A is valid: grant A.
  - Only B is valid: grant B.
  - Both are valid: grant the requester that is not `last_grant`.
- `a_ready`/`b_ready` are high only for the granted requester and only in a free-slot cycle. At most one ready is high per cycle.
- A requester must hold valid, data and amt stable until its ready is seen. The arbiter does not depend on it, because data is sampled only in the grant cycle.
- The output FSM has two states, EMPTY and FULL.
  - EMPTY + grant → FULL: load the rotated data, set `out_src`, update `last_grant`.
  - FULL + out_ready + grant → FULL: back-to-back reload. Full throughput is one job per cycle.
  - FULL + out_ready + no grant → EMPTY.
  - FULL + !out_ready → FULL: `out_data`/`out_src` held stable, both readies low.
  - EMPTY + no grant → EMPTY.
- `out_valid` = (state == FULL).
- `last_grant` updates only on an accepted grant. Its reset value is B, so A wins the first tie.

## Timing
- Latency: a job accepted at edge N appears with `out_valid=1` at N+1. The output is registered and has no combinational input→output path.
- Ready paths are combinational from `*_valid`, `out_valid` and `out_ready`.
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0, state EMPTY, `last_grant`=B.
  - `cnt_a`=`cnt_b`=0.
  - `a_ready`/`b_ready` are also forced to 0 while `rst` is high.
- Reset mid-operation: a held result is discarded immediately (asynchronous). No job is accepted during reset. The first grant after release follows the reset `last_grant`.
- Simultaneous drain and accept in the FULL state loads the new result in the same edge, with no bubble.

## Configuration
- `ROT_ARB_STATS_EN`:
  - Defined: the `cnt_a`/`cnt_b` ports and registers exist. A counter increments by 1 on each output handshake (`out_valid && out_ready`) whose `out_src` matches it. Counters saturate at 255 and do not wrap.
  - Undefined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- The shared package holds:
  - The FSM state typedef (EMPTY, FULL).
  - The requester-ID constants `SRC_A`=0 and `SRC_B`=1.
  - The `CNT_W`=8 constant.
- Sub-module `rot_right`: combinational, parameterised (`WIDTH`, `AMT_W`). Ports: data, amt, result. Instantiated once on the muxed granted operand.

## Test plan
- Reset, then A only: `a_data`=4'b0001, `a_amt`=1, `out_ready`=1 → `a_ready` high in that cycle; next cycle `out_valid`=1, `out_data`=4'b1000, `out_src`=0.
- Both valid each cycle (A: 4'b0011 amt 2; B: 4'b1001 amt 3), `out_ready`=1 → grants A, B, A, B. Results 4'b1100 (A) and 4'b0011 (B). One result per cycle, no bubbles.
- Backpressure: result held with `out_ready`=0 for 3 cycles → `out_data`/`out_src` stable and both readies low. When `out_ready` returns, the next job loads in the same edge.
- amt=0 with `a_data`=4'b1010 → 4'b1010. amt=3 with 4'b1000 → 4'b0001, checking wrap-around.
- Assert `rst` asynchronously while FULL → `out_valid` drops before the next edge. After release, with both requesters valid, A is granted first.
- With `ROT_ARB_STATS_EN` defined: 300 A handshakes → `cnt_a`=255 (saturated), `cnt_b`=0. Jobs held under backpressure are not counted until they are taken.

Source files
------------

// File: rtl/rot_arbiter_pkg.sv
// rot_arbiter shared types and constants.
// FSM state, requester IDs, counter width.
package rot_arbiter_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rot_arbiter_if.sv
// rot_arbiter bus: two job requesters plus result port.
// slave = arbiter side, master = client/consumer side.
// cnt_a/cnt_b exist only with ROT_ARB_STATS_EN.
interface rot_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
);
  import rot_arbiter_pkg::*;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic [AMT_W-1:0] a_amt;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [AMT_W-1:0] b_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
`ifdef ROT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
`endif

  modport slave (
    input  a_valid, a_data, a_amt,
    input  b_valid, b_data, b_amt,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_src
`ifdef ROT_ARB_STATS_EN
    ,
    output cnt_a, cnt_b
`endif
  );

  modport master (
    output a_valid, a_data, a_amt,
    output b_valid, b_data, b_amt,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_src
`ifdef ROT_ARB_STATS_EN
    ,
    input  cnt_a, cnt_b
`endif
  );

endinterface

// File: rtl/rot_arbiter_rot_right.sv
// Combinational rotate-right: result[i] = data[(i+amt) mod WIDTH].
// Ports: data, amt in; result out.
module rot_right #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] result
);

  // WIDTH is a power of two, so the
  // AMT_W-bit sum wraps modulo WIDTH.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [AMT_W-1:0] idx;
    assign idx = AMT_W'(i) + amt;
    assign result[i] = data[idx];
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin arbiter for two rotate requesters into one
// registered output slot. Ports: clk, rst, bus (slave).
// Optional ROT_ARB_STATS_EN adds saturating cnt_a/cnt_b.
module rot_arbiter
  import rot_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  rot_arbiter_if.slave bus
);

  state_t           state, state_nx;
  logic             last_grant, last_nx;
  logic [WIDTH-1:0] data_q, data_nx;
  logic             src_q, src_nx;
  logic [WIDTH-1:0] rot_in, rot_out;
  logic [AMT_W-1:0] rot_amt;
  logic             free;
  logic             gnt_a, gnt_b;
  logic             take;

  assign free = (state == EMPTY) ||
                bus.out_ready;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && free) begin
      unique case (1'b1)
        (bus.a_valid && !bus.b_valid):
          gnt_a = 1'b1;
        (bus.b_valid && !bus.a_valid):
          gnt_b = 1'b1;
        (bus.a_valid && bus.b_valid): begin
          gnt_a = (last_grant == SRC_B);
          gnt_b = (last_grant == SRC_A);
        end
        default: ;
      endcase
    end
  end

  assign take = gnt_a || gnt_b;

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;

  assign rot_in  = gnt_b ? bus.b_data
                         : bus.a_data;
  assign rot_amt = gnt_b ? bus.b_amt
                         : bus.a_amt;

  rot_right #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_rot (
    .data   (rot_in),
    .amt    (rot_amt),
    .result (rot_out)
  );

  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    src_nx   = src_q;
    last_nx  = last_grant;
    unique case (state)
      EMPTY: begin
        if (take) begin
          state_nx = FULL;
          data_nx  = rot_out;
          src_nx   = gnt_b ? SRC_B : SRC_A;
          last_nx  = src_nx;
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          if (take) begin
            data_nx = rot_out;
            src_nx  = gnt_b ? SRC_B : SRC_A;
            last_nx = src_nx;
          end else begin
            state_nx = EMPTY;
          end
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      data_q     <= '0;
      src_q      <= SRC_A;
      last_grant <= SRC_B;
    end else begin
      state      <= state_nx;
      data_q     <= data_nx;
      src_q      <= src_nx;
      last_grant <= last_nx;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

`ifdef ROT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic             drain;

  assign drain = (state == FULL) &&
                 bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (drain) begin
      if (src_q == SRC_A && cnt_a_q != '1)
        cnt_a_q <= cnt_a_q + CNT_W'(1);
      if (src_q == SRC_B && cnt_b_q != '1)
        cnt_b_q <= cnt_b_q + CNT_W'(1);
    end
  end

  assign bus.cnt_a = cnt_a_q;
  assign bus.cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: reference model
// compared every cycle plus directed literal checks.
module tb_rot_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic chk_on;

  rot_arbiter_if #(.WIDTH(4), .AMT_W(2)) bus ();

  rot_arbiter #(.WIDTH(4), .AMT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---- reference model ----
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_src;
  logic       m_last;
  int         m_cnt_a;
  int         m_cnt_b;
  logic [1:0] mg;

  function automatic logic [3:0] m_rot(
    input logic [3:0] d,
    input logic [1:0] amt
  );
    int v;
    int a;
    int r;
    logic [31:0] rv;
    v  = int'(d);
    a  = int'(amt);
    r  = ((v >> a) | (v << (4 - a))) & 15;
    rv = r;
    return rv[3:0];
  endfunction

  // returns {grant_b, grant_a}
  function automatic logic [1:0] m_arb(
    input logic va,
    input logic vb,
    input logic last
  );
    if (va && !vb) return 2'b01;
    if (vb && !va) return 2'b10;
    if (va && vb)  return last ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  assign mg = (!m_valid || bus.out_ready)
            ? m_arb(bus.a_valid, bus.b_valid,
                    m_last)
            : 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 4'd0;
      m_src   <= 1'b0;
      m_last  <= 1'b1;
      m_cnt_a <= 0;
      m_cnt_b <= 0;
    end else begin
      if (m_valid && bus.out_ready) begin
        if (!m_src && m_cnt_a != 255)
          m_cnt_a <= m_cnt_a + 1;
        if (m_src && m_cnt_b != 255)
          m_cnt_b <= m_cnt_b + 1;
      end
      if (mg[0]) begin
        m_valid <= 1'b1;
        m_data  <= m_rot(bus.a_data, bus.a_amt);
        m_src   <= 1'b0;
        m_last  <= 1'b0;
      end else if (mg[1]) begin
        m_valid <= 1'b1;
        m_data  <= m_rot(bus.b_data, bus.b_amt);
        m_src   <= 1'b1;
        m_last  <= 1'b1;
      end else if (m_valid && bus.out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(
    input string      nm,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic [1:0] g;
      g = rst ? 2'b00 : mg;
      chk("m_a_ready", 8'(bus.a_ready), 8'(g[0]));
      chk("m_b_ready", 8'(bus.b_ready), 8'(g[1]));
      chk("m_out_valid", 8'(bus.out_valid),
          8'(m_valid));
      chk("m_out_data", 8'(bus.out_data),
          8'(m_data));
      chk("m_out_src", 8'(bus.out_src),
          8'(m_src));
`ifdef ROT_ARB_STATS_EN
      chk("m_cnt_a", bus.cnt_a, 8'(m_cnt_a));
      chk("m_cnt_b", bus.cnt_b, 8'(m_cnt_b));
`endif
    end
  end

  // ---- stimulus ----
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drive_in(
    input logic       av,
    input logic [3:0] ad,
    input logic [1:0] aa,
    input logic       bv,
    input logic [3:0] bd,
    input logic [1:0] ba
  );
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.a_amt   = aa;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.b_amt   = ba;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_on      = 1'b0;
    rst         = 1'b0;
    drive_in(0, 4'd0, 2'd0, 0, 4'd0, 2'd0);
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_data", 8'(bus.out_data), 8'd0);
    chk("rst_src", 8'(bus.out_src), 8'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    chk_on = 1'b1;

    // A only
    drive_in(1, 4'b0001, 2'd1, 0, 4'd0, 2'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_a_ready", 8'(bus.a_ready), 8'd1);
    @(posedge clk);
    #1 bus.a_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 8'(bus.out_valid), 8'd1);
    chk("t1_data", 8'(bus.out_data), 8'b1000);
    chk("t1_src", 8'(bus.out_src), 8'd0);

    // both valid, alternating grants
    do_reset();
    drive_in(1, 4'b0011, 2'd2, 1, 4'b1001, 2'd3);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_a_ready", 8'(bus.a_ready),
          8'((k % 2) == 0));
      chk("t2_b_ready", 8'(bus.b_ready),
          8'((k % 2) == 1));
      if (k > 0) begin
        chk("t2_valid", 8'(bus.out_valid), 8'd1);
        chk("t2_data", 8'(bus.out_data),
            (k % 2) ? 8'b1100 : 8'b0011);
      end
    end

    // backpressure
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 8'(bus.out_valid), 8'd1);
      chk("bp_data", 8'(bus.out_data), 8'b0011);
      chk("bp_src", 8'(bus.out_src), 8'd1);
      chk("bp_ready", 8'({bus.a_ready,
          bus.b_ready}), 8'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_a", 8'(bus.a_ready), 8'd1);
    @(posedge clk);
    #1 drive_in(0, 4'd0, 2'd0, 0, 4'd0, 2'd0);
    @(negedge clk);
    chk("bp_reload", 8'(bus.out_data), 8'b1100);
    chk("bp_rl_src", 8'(bus.out_src), 8'd0);
    chk("bp_rl_val", 8'(bus.out_valid), 8'd1);

    // amt 0 and wrap-around
    @(posedge clk);
    #1 drive_in(1, 4'b1010, 2'd0, 0, 4'd0, 2'd0);
    @(posedge clk);
    #1 drive_in(1, 4'b1000, 2'd3, 0, 4'd0, 2'd0);
    @(negedge clk);
    chk("amt0", 8'(bus.out_data), 8'b1010);
    @(posedge clk);
    #1 bus.a_valid = 1'b0;
    @(negedge clk);
    chk("amt3", 8'(bus.out_data), 8'b0001);

    // async reset while FULL
    @(posedge clk);
    #1 drive_in(1, 4'b0001, 2'd1, 0, 4'd0, 2'd0);
    @(posedge clk);
    #1 bus.a_valid = 1'b0;
    bus.out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", 8'(bus.out_valid), 8'd0);
    drive_in(1, 4'b0110, 2'd1, 1, 4'b0101, 2'd2);
    bus.out_ready = 1'b1;
    #1;
    chk("ar_ready", 8'({bus.a_ready,
        bus.b_ready}), 8'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ar_first_a", 8'(bus.a_ready), 8'd1);
    chk("ar_first_b", 8'(bus.b_ready), 8'd0);
    @(posedge clk);
    #1 drive_in(0, 4'd0, 2'd0, 0, 4'd0, 2'd0);
    @(negedge clk);
    chk("ar_data", 8'(bus.out_data), 8'b0011);

`ifdef ROT_ARB_STATS_EN
    do_reset();
    drive_in(1, 4'b0001, 2'd0, 0, 4'd0, 2'd0);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.a_valid = 1'b0;
    @(negedge clk);
    chk("st_hold0", bus.cnt_a, 8'd0);
    @(negedge clk);
    chk("st_hold1", bus.cnt_a, 8'd0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("st_pre", bus.cnt_a, 8'd0);
    @(negedge clk);
    chk("st_one", bus.cnt_a, 8'd1);
    @(posedge clk);
    #1 bus.a_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 bus.a_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("st_sat_a", bus.cnt_a, 8'd255);
    chk("st_b", bus.cnt_b, 8'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
